// File: rtl/addr_seq_gen.sv
// rtl/addr_seq_gen.sv - windowed sample address sequencer with step, direction, loop and one-shot modes
module addr_seq_gen #(
    parameter int ADDR_W = 23,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              restart,
    input  logic              count_forward,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] limit_addr,
    input  logic [STEP_W-1:0] step,
    output logic [ADDR_W-1:0] next_address,
    output logic              finish,
    output logic              wrapped,
    output logic              at_end,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, LOAD, ADVANCE, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic              wrap_flag;

    logic [STEP_W-1:0] step_eff;
    logic [ADDR_W:0]   s_ext;
    logic [ADDR_W:0]   fwd_sum;
    logic [ADDR_W:0]   rev_floor;
    logic              fwd_end;
    logic              rev_end;
    logic              end_hit;

    // One extra bit on every compare keeps the top of the address space from wrapping to a small value.
    assign step_eff  = (step == '0) ? STEP_W'(1) : step;
    assign s_ext     = (ADDR_W+1)'(step_eff);
    assign fwd_sum   = {1'b0, ptr} + s_ext;
    assign rev_floor = {1'b0, base_addr} + s_ext;
    assign fwd_end   = fwd_sum > {1'b0, limit_addr};
    assign rev_end   = {1'b0, ptr} < rev_floor;
    assign end_hit   = count_forward ? fwd_end : rev_end;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = ADVANCE;
            ADVANCE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr          <= count_forward ? base_addr : limit_addr;
            next_address <= '0;
            at_end       <= 1'b0;
            wrap_flag    <= 1'b0;
        end else if (restart) begin
            ptr       <= count_forward ? base_addr : limit_addr;
            at_end    <= 1'b0;
            wrap_flag <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    next_address <= ptr;
                    wrap_flag    <= 1'b0;
                end
                ADVANCE: begin
                    // An exhausted one-shot window keeps replaying its final address.
                    if (!at_end) begin
                        if (end_hit) begin
                            if (loop_en) begin
                                ptr       <= count_forward ? base_addr : limit_addr;
                                wrap_flag <= 1'b1;
                            end else begin
                                at_end <= 1'b1;
                            end
                        end else if (count_forward) begin
                            ptr <= fwd_sum[ADDR_W-1:0];
                        end else begin
                            ptr <= ptr - s_ext[ADDR_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign finish  = (state == DONE);
    assign wrapped = finish & wrap_flag;
    assign busy    = (state != IDLE);

endmodule

// File: doc/addr_seq_gen.md
Name: addr_seq_gen

Overview:
- Parametrised successor to the single-shot flash address FSM.
- On each `start` request it returns one sample address from a programmable window `[base_addr, limit_addr]`, then completes with a one-cycle `finish` handshake.
- Supports forward or reverse traversal, a programmable step, and loop or one-shot mode, with wrap and end-of-range flags.
- Sits between the audio playback control FSM and the flash read interface.

Parameters:
- ADDR_W, 23, width of addresses and the internal pointer.
- STEP_W, 4, width of the step input.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request the next address; sampled only in IDLE.
- restart  input  1  synchronous re-arm of the pointer to the window start; aborts any request in flight.
- count_forward  input  1  1 = ascending addresses, 0 = descending.
- loop_en  input  1  1 = wrap at the window end, 0 = stop at the window end.
- base_addr  input  ADDR_W  lowest address of the window.
- limit_addr  input  ADDR_W  highest address of the window.
- step  input  STEP_W  address increment; 0 is treated as 1.
- next_address  output  ADDR_W  address returned by the last completed request.
- finish  output  1  one-cycle completion pulse.
- wrapped  output  1  one-cycle pulse, coincident with `finish`, when this request wrapped the pointer.
- at_end  output  1  sticky; one-shot window exhausted.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Priority: reset > restart > FSM.
- Reset (sync, active-high):
  - state = IDLE; ptr = count_forward ? base_addr : limit_addr.
  - next_address = 0; finish = 0; wrapped = 0; at_end = 0.
  - Reset mid-request aborts the request; no `finish` is issued.
- restart: same ptr and at_end load as reset, state = IDLE, next_address held, no `finish` for an aborted request.
- States and transitions: IDLE -> LOAD -> ADVANCE -> DONE -> IDLE.
  - IDLE: if start = 1, go to LOAD; otherwise stay.
  - LOAD: next_address <= ptr.
  - ADVANCE: pointer update, see below.
  - DONE: finish = 1; wrapped = 1 if set in ADVANCE.
- Latency and throughput:
  - `start` sampled at edge e0 gives `finish` high in the 3rd cycle after e0.
  - next_address is stable from the cycle after LOAD and holds until the next LOAD.
  - Maximum rate is one request per 4 cycles; `start` held high re-triggers on each return to IDLE.
  - `start` is ignored outside IDLE.
- Pointer update in ADVANCE:
  - s = (step == 0) ? 1 : step, zero-extended.
  - All compares use ADDR_W+1 bits, so no modular wrap of the pointer is possible.
  - Forward end condition: ptr + s > limit_addr.
  - Reverse end condition: ptr < base_addr + s.
  - No end condition: ptr <= ptr ± s.
  - End with loop_en = 1: ptr <= forward ? base_addr : limit_addr; set wrapped.
  - End with loop_en = 0: ptr unchanged; at_end <= 1.
- at_end = 1: requests still complete with normal latency and re-return the final address; wrapped stays 0. Cleared only by reset or restart.
- count_forward, loop_en and step are sampled every ADVANCE, so a direction change mid-stream continues from the current ptr.
- base_addr and limit_addr are sampled at reset, restart and ADVANCE; they must be static between a restart and the end of the stream.
- base_addr > limit_addr is unsupported; the bench checks it is never driven.

Test Plan:
- Forward loop, ADDR_W = 23: base 0x10, limit 0x13, step 1, 5 requests -> next_address 0x10, 0x11, 0x12, 0x13, 0x10; wrapped only on the 4th `finish`; `finish` is a single cycle, 3 cycles after each accepted start.
- Reverse loop: base 0, limit 5, step 2, count_forward 0 -> 5, 3, 1, 5; wrapped on the 3rd request.
- Default window: base 0, limit 0x7FFFF, step 1, reverse -> first two requests return 0x7FFFF, 0x7FFFE.
- One-shot: base 0, limit 2, step 1, loop_en 0, 5 requests -> 0, 1, 2, 2, 2; at_end rises on the 3rd `finish` and stays high; wrapped never asserts.
- Top-of-range overflow: base 0x7FFFFC, limit 0x7FFFFF, step 3, forward loop -> 0x7FFFFC, 0x7FFFFF, 0x7FFFFC; no small wrapped-around address appears. Repeat with step 0 to confirm increment 1.
- Abort: start accepted, restart asserted during the ADVANCE cycle -> no `finish`; busy drops next cycle; the following request returns base_addr. Repeat with reset mid-LOAD -> next_address 0, at_end 0.
- Back-to-back: start held high for 12 cycles -> exactly 3 `finish` pulses, spaced 4 cycles apart.
